// File: rtl/dll_lock_monitor.sv
// dll_lock_monitor: measures dll_clk cycles per ext_clk window and
// switches the clock router to the DLL once the ratio is stable.
//
// Ports:
//   dll_clk      DLL output clock, only clock of the block
//   resetb       async active-low reset
//   ext_clk      external pad reference clock (async, < dll_clk/4)
//   dll_ena      async request to run from the DLL
//   ratio_min    lowest acceptable cycles per window (static while enabled)
//   ratio_max    highest acceptable cycles per window (static while enabled)
//   ext_clk_sel  registered router select, 1 = pad clock, 0 = DLL clock
//   dll_locked   high while in LOCKED
//   lock_fault   sticky: lock lost since dll_ena last rose
//   meas_count   dll_clk count of the last completed window
//   meas_done    one-cycle pulse when meas_count updates
module dll_lock_monitor #(
    parameter int WINDOW_LOG2  = 4,
    parameter int GOOD_WINDOWS = 4
) (
    input  logic        dll_clk,
    input  logic        resetb,
    input  logic        ext_clk,
    input  logic        dll_ena,
    input  logic [15:0] ratio_min,
    input  logic [15:0] ratio_max,
    output logic        ext_clk_sel,
    output logic        dll_locked,
    output logic        lock_fault,
    output logic [15:0] meas_count,
    output logic        meas_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] EDGE_ONE  = 1;
    localparam logic [3:0]             GOOD_LAST = 4'(GOOD_WINDOWS - 1);

    state_t                 state, state_n;
    logic                   ena_s1, ena_s2;
    logic                   ext_s1, ext_s2, ext_s3;
    logic                   edge_p;
    logic [15:0]            cyc_cnt, cyc_n;
    logic [WINDOW_LOG2-1:0] edge_cnt, edge_n;
    logic [3:0]             good_cnt, good_n;
    logic                   sel_n, fault_n, done_n;
    logic [15:0]            mcount_n;
    logic                   win_ok;

    assign edge_p     = ext_s2 & ~ext_s3;
    assign win_ok     = (cyc_cnt >= ratio_min) && (cyc_cnt <= ratio_max);
    assign dll_locked = (state == LOCKED);

    always_ff @(posedge dll_clk or negedge resetb) begin
        if (!resetb) begin
            ena_s1      <= 1'b0;
            ena_s2      <= 1'b0;
            ext_s1      <= 1'b0;
            ext_s2      <= 1'b0;
            ext_s3      <= 1'b0;
            state       <= IDLE;
            cyc_cnt     <= '0;
            edge_cnt    <= '0;
            good_cnt    <= '0;
            ext_clk_sel <= 1'b1;
            lock_fault  <= 1'b0;
            meas_count  <= '0;
            meas_done   <= 1'b0;
        end else begin
            ena_s1      <= dll_ena;
            ena_s2      <= ena_s1;
            ext_s1      <= ext_clk;
            ext_s2      <= ext_s1;
            ext_s3      <= ext_s2;
            state       <= state_n;
            cyc_cnt     <= cyc_n;
            edge_cnt    <= edge_n;
            good_cnt    <= good_n;
            ext_clk_sel <= sel_n;
            lock_fault  <= fault_n;
            meas_count  <= mcount_n;
            meas_done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cyc_n    = cyc_cnt;
        edge_n   = edge_cnt;
        good_n   = good_cnt;
        sel_n    = ext_clk_sel;
        fault_n  = lock_fault;
        mcount_n = meas_count;
        done_n   = 1'b0;
        if (!ena_s2) begin
            // disable wins over any window event in the same cycle
            state_n = IDLE;
            sel_n   = 1'b1;
            fault_n = 1'b0;
            cyc_n   = '0;
            edge_n  = '0;
            good_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    sel_n   = 1'b1;
                    fault_n = 1'b0;
                    cyc_n   = '0;
                    edge_n  = '0;
                    good_n  = '0;
                    state_n = ARM;
                end
                ARM: begin
                    if (edge_p) begin
                        cyc_n   = 16'd1;
                        edge_n  = '0;
                        state_n = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (edge_p && (&edge_cnt)) begin
                        // window end; next window starts on this same pulse
                        mcount_n = cyc_cnt;
                        done_n   = 1'b1;
                        cyc_n    = 16'd1;
                        edge_n   = '0;
                        if (win_ok) begin
                            if (state == MEASURE) begin
                                if (good_cnt == GOOD_LAST) begin
                                    state_n = LOCKED;
                                    sel_n   = 1'b0;
                                    good_n  = '0;
                                end else begin
                                    good_n = good_cnt + 4'd1;
                                end
                            end
                        end else begin
                            good_n = '0;
                            if (state == LOCKED) begin
                                state_n = MEASURE;
                                sel_n   = 1'b1;
                                fault_n = 1'b1;
                            end
                        end
                    end else if (&cyc_cnt) begin
                        // reference lost: report a saturated bad window
                        mcount_n = 16'hFFFF;
                        done_n   = 1'b1;
                        good_n   = '0;
                        edge_n   = '0;
                        sel_n    = 1'b1;
                        state_n  = ARM;
                        if (state == LOCKED) fault_n = 1'b1;
                    end else begin
                        cyc_n = cyc_cnt + 16'd1;
                        if (edge_p) edge_n = edge_cnt + EDGE_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_lock_monitor.sv
// tb_dll_lock_monitor: scoreboard bench for dll_lock_monitor.
// Generates ext_clk in whole dll_clk periods and predicts each window.
module tb_dll_lock_monitor;

    typedef struct packed {
        logic [15:0] cnt;
        logic        locked;
        logic        fault;
    } exp_t;

    logic        dll_clk;
    logic        resetb;
    logic        ext_clk;
    logic        dll_ena;
    logic [15:0] ratio_min;
    logic [15:0] ratio_max;
    logic        ext_clk_sel;
    logic        dll_locked;
    logic        lock_fault;
    logic [15:0] meas_count;
    logic        meas_done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    int   ext_per = 8;
    logic ext_run = 1'b0;
    int   ph, acc, nedge;
    logic started;

    logic m_locked, m_fault;
    int   m_good;

    dll_lock_monitor dut (
        .dll_clk    (dll_clk),
        .resetb     (resetb),
        .ext_clk    (ext_clk),
        .dll_ena    (dll_ena),
        .ratio_min  (ratio_min),
        .ratio_max  (ratio_max),
        .ext_clk_sel(ext_clk_sel),
        .dll_locked (dll_locked),
        .lock_fault (lock_fault),
        .meas_count (meas_count),
        .meas_done  (meas_done)
    );

    initial dll_clk = 1'b0;
    always #5 dll_clk = ~dll_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clr(input logic clr_fault);
        m_locked = 1'b0;
        m_good   = 0;
        if (clr_fault) m_fault = 1'b0;
    endtask

    task automatic push_win(input int cnt);
        logic ok;
        exp_t e;
        ok = (cnt >= int'(ratio_min)) && (cnt <= int'(ratio_max));
        if (!m_locked) begin
            if (ok) begin
                m_good++;
                if (m_good == 4) begin
                    m_locked = 1'b1;
                    m_good   = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (!ok) begin
            m_locked = 1'b0;
            m_fault  = 1'b1;
            m_good   = 0;
        end
        e.cnt    = 16'(cnt);
        e.locked = m_locked;
        e.fault  = m_fault;
        q.push_back(e);
    endtask

    // ext_clk generator and window predictor
    initial begin
        ext_clk = 1'b0;
        forever begin
            @(posedge dll_clk);
            #1;
            if (!ext_run) begin
                ext_clk = 1'b0;
                ph      = 0;
                acc     = 0;
                nedge   = 0;
                started = 1'b0;
            end else begin
                if (ph == 0) begin
                    ext_clk = 1'b1;
                    if (started) begin
                        nedge++;
                        if (nedge == 16) begin
                            push_win(acc);
                            acc   = 0;
                            nedge = 0;
                        end
                    end
                    started = 1'b1;
                end else if (ph == ext_per / 2) begin
                    ext_clk = 1'b0;
                end
                if (started) acc++;
                ph = (ph + 1 >= ext_per) ? 0 : ph + 1;
            end
        end
    end

    // scoreboard: pop one prediction per reported window
    initial begin
        exp_t e;
        forever begin
            @(negedge dll_clk);
            if (meas_done === 1'b1) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_done", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("sb_count", 32'(meas_count), 32'(e.cnt));
                    check("sb_locked", 32'(dll_locked), 32'(e.locked));
                    check("sb_sel", 32'(ext_clk_sel), 32'(!e.locked));
                    check("sb_fault", 32'(lock_fault), 32'(e.fault));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge dll_clk);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++)
            @(negedge dll_clk);
        check(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic reset_outs(input string tag);
        check({tag, "_sel"}, 32'(ext_clk_sel), 32'd1);
        check({tag, "_locked"}, 32'(dll_locked), 32'd0);
        check({tag, "_fault"}, 32'(lock_fault), 32'd0);
        check({tag, "_count"}, 32'(meas_count), 32'd0);
        check({tag, "_done"}, 32'(meas_done), 32'd0);
    endtask

    initial begin
        int lat;
        resetb    = 1'b0;
        dll_ena   = 1'b0;
        ratio_min = 16'd120;
        ratio_max = 16'd136;
        m_fault   = 1'b0;
        model_clr(1'b1);
        cycles(3);
        reset_outs("reset");

        // nominal lock at period 8
        resetb = 1'b1;
        cycles(2);
        dll_ena = 1'b1;
        cycles(6);
        check("arm_sel", 32'(ext_clk_sel), 32'd1);
        ext_per = 8;
        ext_run = 1'b1;
        cycles(6 * 128 + 40);
        check("lock_locked", 32'(dll_locked), 32'd1);
        check("lock_sel", 32'(ext_clk_sel), 32'd0);

        // slow excursion then relock
        ext_per = 9;
        cycles(320);
        ext_per = 8;
        cycles(900);
        check("relock_fault", 32'(lock_fault), 32'd1);
        check("relock_locked", 32'(dll_locked), 32'd1);
        check("relock_sel", 32'(ext_clk_sel), 32'd0);

        // reference stops: timeout while locked
        ext_run = 1'b0;
        q.push_back('{16'hFFFF, 1'b0, 1'b1});
        model_clr(1'b0);
        m_fault = 1'b1;
        drain("timeout_drain", 70000);
        check("timeout_sel", 32'(ext_clk_sel), 32'd1);
        check("timeout_locked", 32'(dll_locked), 32'd0);
        check("timeout_fault", 32'(lock_fault), 32'd1);

        // relock from ARM, then drop dll_ena
        ext_run = 1'b1;
        cycles(6 * 128 + 40);
        check("arm_relock", 32'(dll_locked), 32'd1);
        ext_run = 1'b0;
        drain("ena_drain", 50);
        cycles(10);
        dll_ena = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && ext_clk_sel !== 1'b1; i++) begin
            @(negedge dll_clk);
            lat++;
        end
        check("ena_drop_lat_ok", 32'(lat <= 3 && ext_clk_sel === 1'b1), 32'd1);
        check("ena_drop_locked", 32'(dll_locked), 32'd0);
        check("ena_drop_fault", 32'(lock_fault), 32'd0);

        // period 10: out of range, never locks
        model_clr(1'b1);
        ext_per = 10;
        dll_ena = 1'b1;
        cycles(6);
        ext_run = 1'b1;
        cycles(6 * 160 + 40);
        check("slow_sel", 32'(ext_clk_sel), 32'd1);
        check("slow_locked", 32'(dll_locked), 32'd0);

        // async reset mid-window
        cycles(37);
        resetb  = 1'b0;
        ext_run = 1'b0;
        dll_ena = 1'b0;
        q.delete();
        #1;
        reset_outs("midreset");
        cycles(3);
        model_clr(1'b1);
        ratio_min = 16'd200;
        ratio_max = 16'd100;
        resetb    = 1'b1;
        cycles(2);
        dll_ena = 1'b1;
        ext_per = 8;
        cycles(6);
        ext_run = 1'b1;
        cycles(6 * 128 + 40);
        check("inverted_locked", 32'(dll_locked), 32'd0);
        check("inverted_sel", 32'(ext_clk_sel), 32'd1);
        ext_run = 1'b0;
        drain("final_drain", 50);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dll_lock_monitor.md
DLL_LOCK_MONITOR -- requirements
Module: dll_lock_monitor

Interface
REQ-001 Parameter WINDOW_LOG2, default 4, meaning: measurement window length is 2^WINDOW_LOG2 ext_clk periods.
REQ-002 Parameter GOOD_WINDOWS, default 4, meaning: consecutive in-range windows required to declare lock (range 1..15).
REQ-003 dll_clk  input  1  DLL output clock; the only clock of the block.
REQ-004 resetb  input  1  reset, asynchronous, active-low.
REQ-005 ext_clk  input  1  external pad reference clock, asynchronous to dll_clk; frequency SHALL be below dll_clk/4.
REQ-006 dll_ena  input  1  request to run from the DLL, asynchronous (housekeeping register).
REQ-007 ratio_min  input  16  lowest acceptable dll_clk cycles per window, static while dll_ena=1.
REQ-008 ratio_max  input  16  highest acceptable dll_clk cycles per window, static while dll_ena=1.
REQ-009 ext_clk_sel  output  1  registered clock select for the downstream clock router (1=external pad clock, 0=DLL clock).
REQ-010 dll_locked  output  1  high while in state LOCKED.
REQ-011 lock_fault  output  1  sticky flag: lock was lost since dll_ena last rose.
REQ-012 meas_count  output  16  dll_clk count of the most recently completed window.
REQ-013 meas_done  output  1  one-cycle pulse when meas_count updates.

Function
REQ-014 ext_clk and dll_ena SHALL each pass a two-flop synchronizer on dll_clk; ext_clk SHALL have a third flop, edge pulse = sync2 & ~sync3 (one cycle per ext_clk rising edge).
REQ-015 States: IDLE, ARM, MEASURE, LOCKED; encoding is implementer's choice.
REQ-016 IDLE: ext_clk_sel=1, counters cleared, lock_fault cleared; to ARM when synced dll_ena=1.
REQ-017 ARM: wait for first edge pulse; on it load cycle counter=1, edge counter=0, go to MEASURE.
REQ-018 MEASURE/LOCKED: cycle counter increments every cycle, saturating at 16'hFFFF; edge counter increments on each edge pulse.
REQ-019 Window end = edge pulse that makes edge counter reach 2^WINDOW_LOG2; count = cycle counter value in that cycle (cycles between the start and end pulses); next window starts on the same pulse (counter reloads to 1, no gap).
REQ-020 At window end: meas_count<=count, meas_done=1 next cycle; window good iff ratio_min <= count <= ratio_max (unsigned, inclusive).
REQ-021 MEASURE: good window increments good counter; bad window clears it; when good counter reaches GOOD_WINDOWS, go to LOCKED and ext_clk_sel<=0 in the same register update.
REQ-022 LOCKED: any bad window -> ext_clk_sel<=1, lock_fault<=1, good counter cleared, state MEASURE (continuous measurement, no ARM).
REQ-023 Timeout: cycle counter reaching 16'hFFFF before window end SHALL be treated as a bad window with meas_count=16'hFFFF, then state ARM.
REQ-024 Synced dll_ena=0 in any state SHALL go to IDLE next cycle, ext_clk_sel<=1, overriding any simultaneous window event.
REQ-025 ratio_min > ratio_max SHALL make every window bad (never locks).
REQ-026 ext_clk_sel SHALL only change in the cycle after a state transition; no combinational path from inputs to outputs.

Reset
REQ-027 resetb low SHALL asynchronously force IDLE, ext_clk_sel=1, dll_locked=0, lock_fault=0, meas_count=0, meas_done=0, all counters and synchronizer flops 0.
REQ-028 resetb deassertion mid-operation SHALL restart from IDLE; no partial window is reported.

Verification
REQ-029 Defaults, ext_clk period 8 dll_clk, min=120, max=136, dll_ena=1 -> meas_count=128 each window, dll_locked=1 and ext_clk_sel=0 one cycle after 4th window end.
REQ-030 Same with ext_clk period 10 -> meas_count=160 every window, ext_clk_sel stays 1, dll_locked stays 0.
REQ-031 Locked, then ext_clk held low -> after 65535 cycles meas_count=16'hFFFF, ext_clk_sel=1, lock_fault=1, state ARM.
REQ-032 Locked, dll_ena dropped -> ext_clk_sel=1 within 3 dll_clk cycles, dll_locked=0, lock_fault=0.
REQ-033 Locked, one window of period 9 (count 144) -> ext_clk_sel=1, lock_fault=1; relock after 4 further good windows with lock_fault still 1.
REQ-034 resetb pulsed low mid-window -> all outputs at REQ-027 values immediately; min=200, max=100 afterwards -> never locks.
